// File: rtl/mac_pkg.sv
// Shared types and overflow-aware adders for the vector MAC engine.
package mac_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int unsigned MAX_ACC = 64;

  // Unsigned add of the low w bits; returns {carry_out, sum}, sum clamped to all-ones when sat.
  function automatic logic [MAX_ACC:0] sat_add_u(input logic [MAX_ACC-1:0] a,
                                                 input logic [MAX_ACC-1:0] b,
                                                 input int unsigned w,
                                                 input logic sat);
    logic [MAX_ACC-1:0] mask;
    logic [MAX_ACC:0]   s;
    logic [MAX_ACC-1:0] r;
    logic               ovf;
    mask = (w >= MAX_ACC) ? {MAX_ACC{1'b1}} : ((64'd1 << w) - 64'd1);
    s    = {1'b0, a & mask} + {1'b0, b & mask};
    ovf  = s[w];
    if (sat && ovf) r = mask;
    else            r = s[MAX_ACC-1:0] & mask;
    return {ovf, r};
  endfunction

  // Two's-complement add of the low w bits; returns {overflow, sum}, clamped to min/max when sat.
  function automatic logic [MAX_ACC:0] sat_add_s(input logic [MAX_ACC-1:0] a,
                                                 input logic [MAX_ACC-1:0] b,
                                                 input int unsigned w,
                                                 input logic sat);
    logic [MAX_ACC-1:0] mask;
    logic [MAX_ACC-1:0] r;
    logic               sa;
    logic               sb;
    logic               ovf;
    mask = (w >= MAX_ACC) ? {MAX_ACC{1'b1}} : ((64'd1 << w) - 64'd1);
    r    = (a + b) & mask;
    sa   = a[w-1];
    sb   = b[w-1];
    ovf  = (sa == sb) && (r[w-1] != sa);
    if (sat && ovf) r = sa ? (64'd1 << (w - 1)) : (mask >> 1);
    else            r = r;
    return {ovf, r};
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One MAC lane: registered a*b product (stage 1) feeding a wrapping or saturating accumulator (stage 2).
module mac_lane
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int SIGNED     = 0,
  parameter int SATURATE   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  take,
  input  logic                  upd,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0]  acc,
  output logic                  ovf
);

  localparam int PW = 2 * DATA_WIDTH;

  logic [PW-1:0]        mul;
  logic [PW-1:0]        prod;
  logic [ACC_WIDTH-1:0] ext;
  logic [MAX_ACC:0]     res;

  // Operands are widened before multiplying so the product keeps all 2*DATA_WIDTH bits.
  always_comb begin
    mul = '0;
    ext = '0;
    res = '0;
    if (SIGNED != 0) begin
      mul = PW'($signed(a)) * PW'($signed(b));
      ext = ACC_WIDTH'($signed(prod));
      res = sat_add_s(MAX_ACC'(acc), MAX_ACC'(ext), ACC_WIDTH, SATURATE != 0);
    end else begin
      mul = PW'(a) * PW'(b);
      ext = ACC_WIDTH'(prod);
      res = sat_add_u(MAX_ACC'(acc), MAX_ACC'(ext), ACC_WIDTH, SATURATE != 0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       prod <= '0;
    else if (clr)  prod <= '0;
    else if (take) prod <= mul;
    else           prod <= prod;
  end

  // Overflow flag stays set until the result is consumed or the lane is cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (clr || flush) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (upd) begin
      acc <= res[ACC_WIDTH-1:0];
      ovf <= ovf | res[MAX_ACC];
    end else begin
      acc <= acc;
      ovf <= ovf;
    end
  end

endmodule

// File: rtl/mac_vec_array.sv
// LANES-wide pipelined MAC: streams beats into per-lane accumulators and holds the
// result vector under a valid/ready handshake after each in_last beat.
module mac_vec_array
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 8,
  parameter int ACC_WIDTH  = 3 * DATA_WIDTH,
  parameter int SIGNED     = 0,
  parameter int SATURATE   = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_last,
  input  logic [LANES*DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0]       b_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*ACC_WIDTH-1:0]  acc_out,
  output logic [LANES-1:0]            ovf_out,
  output logic [CNT_WIDTH-1:0]        beat_cnt
);

  state_t state;
  state_t state_next;
  logic   accept;
  logic   flush;
  logic   v1;
  logic   l1;
  logic   l2;

  assign accept = in_valid && in_ready;
  assign flush  = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      state <= ACCUM;
    else if (clr) state <= ACCUM;
    else          state <= state_next;
  end

  // HOLD is entered one edge after stage 2 has absorbed the last product (l2).
  always_comb begin
    state_next = state;
    case (state)
      ACCUM:   if (accept && in_last) state_next = DRAIN; else state_next = ACCUM;
      DRAIN:   if (l2) state_next = HOLD; else state_next = DRAIN;
      HOLD:    if (out_ready) state_next = ACCUM; else state_next = HOLD;
      default: state_next = ACCUM;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACCUM:   in_ready  = 1'b1;
      DRAIN:   in_ready  = 1'b0;
      HOLD:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      l1 <= 1'b0;
      l2 <= 1'b0;
    end else if (clr) begin
      v1 <= 1'b0;
      l1 <= 1'b0;
      l2 <= 1'b0;
    end else begin
      v1 <= accept;
      l1 <= accept && in_last;
      l2 <= v1 && l1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  beat_cnt <= '0;
    else if (clr || flush)    beat_cnt <= '0;
    else if (v1 && (beat_cnt != {CNT_WIDTH{1'b1}}))
                              beat_cnt <= beat_cnt + CNT_WIDTH'(1);
    else                      beat_cnt <= beat_cnt;
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mac_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH),
      .SIGNED     (SIGNED),
      .SATURATE   (SATURATE)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .take  (accept),
      .upd   (v1),
      .flush (flush),
      .a     (a_in[i*DATA_WIDTH +: DATA_WIDTH]),
      .b     (b_in),
      .acc   (acc_out[i*ACC_WIDTH +: ACC_WIDTH]),
      .ovf   (ovf_out[i])
    );
  end

endmodule

// File: tb/tb_mac_vec_array.sv
// Scoreboard bench: four mac_vec_array configurations share one input stream; expected
// results are queued per instance at issue time and checked when each result is consumed.
module tb_mac_vec_array;

  typedef struct packed {
    logic [95:0] acc;
    logic [3:0]  ovf;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [31:0] a_in = 32'd0;
  logic [7:0]  b_in = 8'd0;
  logic        out_ready = 1'b0;

  logic        rdy0, rdy1, rdy2, rdy3;
  logic        ov0, ov1, ov2, ov3;
  logic [95:0] acc0, acc1;
  logic [63:0] acc2, acc3;
  logic [3:0]  ovf0, ovf1, ovf2, ovf3;
  logic [15:0] cnt0, cnt1, cnt2, cnt3;

  logic [95:0] g_acc [4];
  logic [3:0]  g_ovf [4];
  logic [15:0] g_cnt [4];
  logic        g_rdy [4];
  logic        g_ov  [4];

  exp_t exp_q [4][$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  mac_vec_array #(.DATA_WIDTH(8), .LANES(4), .ACC_WIDTH(24), .SIGNED(0), .SATURATE(0), .CNT_WIDTH(16)) u_d0 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy0), .in_last(in_last),
    .a_in(a_in), .b_in(b_in), .out_valid(ov0), .out_ready(out_ready), .acc_out(acc0),
    .ovf_out(ovf0), .beat_cnt(cnt0));
  mac_vec_array #(.DATA_WIDTH(8), .LANES(4), .ACC_WIDTH(24), .SIGNED(1), .SATURATE(0), .CNT_WIDTH(16)) u_d1 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy1), .in_last(in_last),
    .a_in(a_in), .b_in(b_in), .out_valid(ov1), .out_ready(out_ready), .acc_out(acc1),
    .ovf_out(ovf1), .beat_cnt(cnt1));
  mac_vec_array #(.DATA_WIDTH(8), .LANES(4), .ACC_WIDTH(16), .SIGNED(0), .SATURATE(1), .CNT_WIDTH(16)) u_d2 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy2), .in_last(in_last),
    .a_in(a_in), .b_in(b_in), .out_valid(ov2), .out_ready(out_ready), .acc_out(acc2),
    .ovf_out(ovf2), .beat_cnt(cnt2));
  mac_vec_array #(.DATA_WIDTH(8), .LANES(4), .ACC_WIDTH(16), .SIGNED(0), .SATURATE(0), .CNT_WIDTH(16)) u_d3 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy3), .in_last(in_last),
    .a_in(a_in), .b_in(b_in), .out_valid(ov3), .out_ready(out_ready), .acc_out(acc3),
    .ovf_out(ovf3), .beat_cnt(cnt3));

  // 16-bit lanes are widened into 24-bit slots so every instance compares the same way.
  always_comb begin
    g_acc[0] = acc0;
    g_acc[1] = acc1;
    g_acc[2] = '0;
    g_acc[3] = '0;
    for (int l = 0; l < 4; l++) begin
      g_acc[2][l*24 +: 24] = {8'd0, acc2[l*16 +: 16]};
      g_acc[3][l*24 +: 24] = {8'd0, acc3[l*16 +: 16]};
    end
    g_ovf[0] = ovf0; g_ovf[1] = ovf1; g_ovf[2] = ovf2; g_ovf[3] = ovf3;
    g_cnt[0] = cnt0; g_cnt[1] = cnt1; g_cnt[2] = cnt2; g_cnt[3] = cnt3;
    g_rdy[0] = rdy0; g_rdy[1] = rdy1; g_rdy[2] = rdy2; g_rdy[3] = rdy3;
    g_ov[0]  = ov0;  g_ov[1]  = ov1;  g_ov[2]  = ov2;  g_ov[3]  = ov3;
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  function automatic exp_t mk(input logic [23:0] l0, input logic [23:0] l1, input logic [23:0] l2,
                              input logic [23:0] l3, input logic [3:0] ovf, input logic [15:0] cnt);
    exp_t e;
    e.acc = {l3, l2, l1, l0};
    e.ovf = ovf;
    e.cnt = cnt;
    return e;
  endfunction

  task automatic push(input exp_t e0, input exp_t e1, input exp_t e2, input exp_t e3);
    exp_q[0].push_back(e0);
    exp_q[1].push_back(e1);
    exp_q[2].push_back(e2);
    exp_q[3].push_back(e3);
  endtask

  task automatic push_all(input exp_t e);
    push(e, e, e, e);
  endtask

  // Monitor: every consumed result is popped and compared per instance.
  always @(negedge clk) begin
    if (out_ready) begin
      for (int d = 0; d < 4; d++) begin
        if (g_ov[d]) begin
          if (exp_q[d].size() == 0) begin
            check($sformatf("sb_unexpected_d%0d", d), 128'd1, 128'd0);
          end else begin
            mon_e = exp_q[d].pop_front();
            check($sformatf("sb_result_d%0d", d), 128'({g_acc[d], g_ovf[d], g_cnt[d]}), 128'(mon_e));
          end
        end
      end
    end
  end

  task automatic beat(input logic [31:0] a, input logic [7:0] b, input logic last);
    a_in = a;
    b_in = b;
    in_last = last;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic check_idle(input string name);
    for (int d = 0; d < 4; d++)
      check($sformatf("%s_d%0d", name, d),
            128'({g_rdy[d], g_ov[d], g_ovf[d], g_cnt[d], g_acc[d]}),
            128'({1'b1, 1'b0, 4'd0, 16'd0, 96'd0}));
  endtask

  task automatic finish_result(input string name);
    int n;
    n = 0;
    while (!ov0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!ov0) begin
      check({name, "_timeout"}, 128'd0, 128'd1);
    end else begin
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Two-beat unsigned dot product, latency and stall behaviour.
    push_all(mk(24'd5, 24'd7, 24'd9, 24'd11, 4'b0000, 16'd2));
    beat(32'h04030201, 8'd2, 1'b0);
    beat(32'h01010101, 8'd3, 1'b1);
    @(negedge clk);
    check("lat_e0p1_valid", 128'(ov0), 128'd0);
    @(negedge clk);
    check("lat_e0p2_valid", 128'(ov0), 128'd0);
    @(negedge clk);
    check("lat_e0p3_valid", 128'(ov0), 128'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check("hold_stall", 128'({rdy0, ov0, acc0}), 128'({1'b0, 1'b1, 24'd11, 24'd9, 24'd7, 24'd5}));
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check_idle("after_release");

    // Signed vs unsigned interpretation, one-term result.
    push(mk(24'h0004F1, 24'h00027B, 24'h000280, 24'h00000A, 4'b0000, 16'd1),
         mk(24'hFFFFF1, 24'h00027B, 24'hFFFD80, 24'h00000A, 4'b0000, 16'd1),
         mk(24'h0004F1, 24'h00027B, 24'h000280, 24'h00000A, 4'b0000, 16'd1),
         mk(24'h0004F1, 24'h00027B, 24'h000280, 24'h00000A, 4'b0000, 16'd1));
    beat(32'h02807FFD, 8'd5, 1'b1);
    finish_result("signed");

    // 255*255 twice: overflows only the 16-bit instances, lane 3 stays in range.
    push(mk(24'h01FC02, 24'h01FC02, 24'h01FC02, 24'h0001FE, 4'b0000, 16'd2),
         mk(24'h000002, 24'h000002, 24'h000002, 24'hFFFFFE, 4'b0000, 16'd2),
         mk(24'h00FFFF, 24'h00FFFF, 24'h00FFFF, 24'h0001FE, 4'b0111, 16'd2),
         mk(24'h00FC02, 24'h00FC02, 24'h00FC02, 24'h0001FE, 4'b0111, 16'd2));
    beat(32'h01FFFFFF, 8'hFF, 1'b0);
    beat(32'h01FFFFFF, 8'hFF, 1'b1);
    finish_result("overflow");

    // Synchronous clear aborts accumulation and drops the beat offered with it.
    beat(32'h01010101, 8'd7, 1'b0);
    clr = 1'b1;
    in_valid = 1'b1;
    in_last = 1'b1;
    a_in = 32'h09090909;
    b_in = 8'd9;
    @(posedge clk);
    #1;
    clr = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    @(negedge clk);
    check_idle("clr");
    @(negedge clk);
    check_idle("clr_settled");
    push_all(mk(24'd1, 24'd2, 24'd3, 24'd4, 4'b0000, 16'd1));
    beat(32'h04030201, 8'd1, 1'b1);
    finish_result("post_clr");

    // Asynchronous reset while draining, then a clean restart.
    beat(32'h01010101, 8'd1, 1'b0);
    beat(32'h02020202, 8'd1, 1'b1);
    rst = 1'b1;
    #1;
    check_idle("rst_drain");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("rst_no_residue");
    push_all(mk(24'd12, 24'd9, 24'd6, 24'd3, 4'b0000, 16'd1));
    beat(32'h01020304, 8'd3, 1'b1);
    finish_result("post_rst");

    repeat (3) @(negedge clk);
    for (int d = 0; d < 4; d++)
      check($sformatf("queue_empty_d%0d", d), 128'(exp_q[d].size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
